// File: rtl/hh_gate_scheduler.sv
// Time-multiplexed scheduler that walks every (neuron, gate) pair through one
// shared Hodgkin-Huxley gate-update unit and keeps the per-neuron gate state.
module hh_gate_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int DW = 16,
  parameter int TIMEOUT = 64,
  parameter logic [DW-1:0] M_INIT = 16'h06C9,
  parameter logic [DW-1:0] H_INIT = 16'h4C4A,
  parameter logic [DW-1:0] N_INIT = 16'h28B4,
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_start,
  output logic          busy,
  output logic          step_done,
  output logic [NW-1:0] v_idx,
  input  logic [DW-1:0] v_data,
  output logic          upd_valid,
  input  logic          upd_ready,
  output logic [1:0]    upd_sel,
  output logic [DW-1:0] upd_v,
  output logic [DW-1:0] upd_x,
  input  logic          res_valid,
  input  logic [DW-1:0] res_x,
  output logic          err_timeout,
  input  logic          clr_err,
  input  logic [NW-1:0] rd_neuron,
  input  logic [1:0]    rd_gate,
  output logic [DW-1:0] rd_data
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  state_t          state;
  logic [NW-1:0]   neuron;
  logic [1:0]      gate;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   v_hold;
  logic [DW-1:0]   res_hold;
  logic [DW-1:0]   gates [N_NEURONS][3];

  logic            last_gate;
  logic            pass_end;
  logic            timeout_hit;
  logic            advance;
  logic [1:0]      next_gate;
  logic [NW-1:0]   next_neuron;

  assign v_idx   = neuron;
  assign upd_sel = gate;

  // v_idx only reaches the new neuron once ISSUE is entered, so the first gate
  // of each neuron forwards v_data directly while v_hold captures it for the rest.
  assign upd_v = (state == ISSUE && gate == 2'd0) ? v_data : v_hold;

  always_comb begin
    last_gate   = (gate == 2'd2);
    pass_end    = last_gate && (neuron == NW'(N_NEURONS - 1));
    next_gate   = last_gate ? 2'd0 : gate + 2'd1;
    next_neuron = last_gate ? neuron + NW'(1) : neuron;
    timeout_hit = (state == WAIT) && !res_valid && (timer == TW'(TIMEOUT - 1));
    advance     = (state == WRITE) || timeout_hit;
  end

  always_comb begin
    rd_data = '0;
    if (rd_gate != 2'd3 && int'(rd_neuron) < N_NEURONS)
      rd_data = gates[rd_neuron][rd_gate];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      neuron      <= '0;
      gate        <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      upd_valid   <= 1'b0;
      upd_x       <= '0;
      v_hold      <= '0;
      res_hold    <= '0;
      err_timeout <= 1'b0;
      for (int unsigned n = 0; n < N_NEURONS; n++) begin
        gates[n][0] <= M_INIT;
        gates[n][1] <= H_INIT;
        gates[n][2] <= N_INIT;
      end
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          if (step_start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            neuron    <= '0;
            gate      <= '0;
            upd_valid <= 1'b1;
            upd_x     <= gates[0][0];
          end
        end
        ISSUE: begin
          if (gate == 2'd0)
            v_hold <= v_data;
          if (upd_ready) begin
            upd_valid <= 1'b0;
            timer     <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (res_valid) begin
            res_hold <= res_x;
            state    <= WRITE;
          end
        end
        WRITE: begin
          gates[neuron][gate] <= res_hold[DW-1] ? '0 : res_hold;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A timed-out item skips its write but advances exactly like WRITE.
      if (advance) begin
        if (pass_end) begin
          state     <= DONE;
          step_done <= 1'b1;
          neuron    <= '0;
          gate      <= '0;
        end else begin
          state     <= ISSUE;
          upd_valid <= 1'b1;
          neuron    <= next_neuron;
          gate      <= next_gate;
          upd_x     <= gates[next_neuron][next_gate];
        end
      end

      if (timeout_hit)
        err_timeout <= 1'b1;
      else if (clr_err)
        err_timeout <= 1'b0;
    end
  end

endmodule

// File: doc/hh_gate_scheduler.md
Name: hh_gate_scheduler

Overview:
- Time-multiplexes one shared Hodgkin-Huxley gating-update datapath across N_NEURONS neurons × 3 gates (m, h, n).
- On each simulation step it walks every (neuron, gate) pair in order, issues one update request with the current V and gate value, and writes the returned value back into its internal gate state file.
- It sits between the step sequencer, which pulses step_start, and the gate-update unit.

Parameters:
N_NEURONS, 4, number of neurons served; index width NW = max(1, clog2(N_NEURONS))
DW, 16, data width; V is signed Q8.8 mV, gate values are Q1.15 in [0, 0x7FFF]
TIMEOUT, 64, maximum cycles to wait for a result before skipping the item
M_INIT, 16'h06C9, reset value of every m register (≈0.053)
H_INIT, 16'h4C4A, reset value of every h register (≈0.596)
N_INIT, 16'h28B4, reset value of every n register (≈0.318)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
step_start  in  1  single-cycle request to run one full update pass
busy  out  1  high from the cycle after accepted step_start through the DONE cycle
step_done  out  1  one-cycle pulse when a pass completes
v_idx  out  NW  neuron index whose V is requested
v_data  in  DW  membrane potential of neuron v_idx, combinational source
upd_valid  out  1  request valid to the gate-update unit
upd_ready  in  1  gate-update unit accepts the request
upd_sel  out  2  0=m, 1=h, 2=n (3 never driven)
upd_v  out  DW  V operand
upd_x  out  DW  current gate value operand
res_valid  in  1  result valid, single cycle
res_x  in  DW  updated gate value, signed
err_timeout  out  1  sticky flag: at least one item timed out
clr_err  in  1  clears err_timeout
rd_neuron  in  NW  debug/readout neuron index
rd_gate  in  2  debug/readout gate select
rd_data  out  DW  combinational read of gate[rd_neuron][rd_gate]; 0 for rd_gate=3 or out-of-range neuron

Behaviour:
- Reset (async): FSM=IDLE; neuron and gate counters=0; all m/h/n registers=M_INIT/H_INIT/N_INIT; busy=0; step_done=0; upd_valid=0; upd_v/upd_x/upd_sel=0; err_timeout=0; wait timer=0. Reset mid-pass aborts the pass; no step_done is produced.
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE: step_start=1 → ISSUE with neuron=0, gate=0.
  - On every entry to ISSUE with gate=0, latch v_data into upd_v. v_idx is driven from the neuron counter at all times.
  - All three gates of a neuron therefore use the same V.
- ISSUE: upd_valid=1. upd_sel=gate counter; upd_x=stored value for (neuron, gate).
  - upd_v/upd_x/upd_sel are held stable while upd_valid=1.
  - The handshake completes on a clock edge with upd_valid&upd_ready → WAIT, timer=0.
  - upd_valid drops in WAIT.
- WAIT: timer increments each cycle.
  - res_valid=1 → capture res_x, go to WRITE.
  - Otherwise, timer==TIMEOUT-1 → set err_timeout, keep the old gate value, then advance as WRITE would (no write).
  - If res_valid and the timeout coincide, the result wins.
  - res_valid in any state other than WAIT is ignored.
- WRITE: store saturate(res_x) into the gate register. Saturation: negative → 0; otherwise unchanged (max 0x7FFF).
  - Then advance: gate 0→1→2; after gate 2, neuron+1 and gate=0.
  - After neuron N_NEURONS-1, gate 2 → DONE; else → ISSUE.
- DONE: step_done=1 for exactly one cycle → IDLE. busy=0 in IDLE only.
- step_start while not IDLE is ignored; it is not queued.
- rd_data reflects a write on the cycle after WRITE.
- err_timeout: set has priority over clr_err in the same cycle. Otherwise clr_err=1 clears it.
- Timing with upd_ready tied high and the result one cycle after acceptance: 3 cycles per item. A full pass with N_NEURONS=4 is 12×3 = 36 cycles plus 1 DONE cycle; step_done asserts 37 cycles after the step_start edge.

Test Plan:
- Reset values: after rst, rd_data for (0,0)/(0,1)/(0,2) = 0x06C9/0x4C4A/0x28B4; busy=0; upd_valid=0; err_timeout=0.
- Nominal pass: v_data = -16'sd16640 (-65 mV) for all neurons, upd_ready=1, model returns upd_x+1 one cycle later → step_done at cycle 37; every gate = init+1; upd_sel order is 0,1,2 repeated per neuron.
- Backpressure: upd_ready low for 5 cycles at item (2,1) → upd_valid, upd_sel=1, upd_v and upd_x all held constant; no state advance; pass completes 5 cycles late.
- Saturation: model returns 16'h8005 for (1,2) → stored value 0.
- Timeout: no res_valid for item (3,0) → err_timeout rises after TIMEOUT cycles; m of neuron 3 unchanged; pass still completes. clr_err clears the flag; clr_err in the same cycle as a new timeout leaves it set.
- Control corner cases:
  - step_start while busy → ignored; only one step_done pulse.
  - rst asserted mid-WAIT → immediate IDLE and init values; a later res_valid is ignored.
